// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// serialiser state encoding and STATUS bit positions.
package uart_tx_mmio_pkg;

   localparam logic [1:0] UART_TXDATA = 2'd0;
   localparam logic [1:0] UART_STATUS = 2'd1;
   localparam logic [1:0] UART_CTRL   = 2'd2;
   localparam logic [1:0] UART_BAUD   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_FULL    = 1;
   localparam int STAT_EMPTY   = 2;
   localparam int STAT_OVF     = 3;
   localparam int STAT_CNT_LSB = 8;

   // A divider of 0 behaves like 1, so both reload the bit timer with 0.
   function automatic logic [15:0] bit_reload(input logic [15:0] div);
      return (div == 16'd0) ? 16'd0 : div - 16'd1;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO; push and pop may coincide, including on a full FIFO.
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           din_i,
   output logic [WIDTH-1:0]           dout_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             push_ok, pop_ok;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];

   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter sitting beside data RAM on the MEM-stage port.
//   state    | meaning
//   ST_IDLE  | line high; pops next byte when tx_en and FIFO not empty
//   ST_START | start bit (low) for one bit period
//   ST_DATA  | 8 data bits, LSB first
//   ST_STOP  | stop bit (high) for one bit period
module uart_tx_mmio
   import uart_tx_mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h1FD0_0000,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [3:0]  sel_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        hit_o,
   output logic        tx_o,
   output logic        irq_o
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   tx_state_e       state_q, state_d;
   logic [15:0]     cnt_q, cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic            irq_q, irq_d;
   logic            tx_en_q, irq_en_q, ovf_q;
   logic [15:0]     div_q;

   logic [1:0]      offset;
   logic            wr, push_req, fifo_push, fifo_pop;
   logic            fifo_full, fifo_empty;
   logic [7:0]      fifo_dout;
   logic [CW-1:0]   fifo_count;
   logic [31:0]     status;
   logic            bit_end;
   logic            unused_ok;

   assign hit_o     = ce_i && (addr_i[31:4] == BASE_ADDR[31:4]);
   assign offset    = addr_i[3:2];
   assign wr        = hit_o && we_i;
   assign push_req  = wr && (offset == UART_TXDATA) && sel_i[0];
   // A push into a full FIFO survives only when the serialiser pops in the same cycle.
   assign fifo_push = push_req && (!fifo_full || fifo_pop);
   assign unused_ok = ^{addr_i[1:0], sel_i[3:2], data_i[31:16]};

   uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .din_i   (data_i[7:0]),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      status                        = '0;
      status[STAT_BUSY]             = (state_q != ST_IDLE);
      status[STAT_FULL]             = fifo_full;
      status[STAT_EMPTY]            = fifo_empty;
      status[STAT_OVF]              = ovf_q;
      status[STAT_CNT_LSB +: CW]    = fifo_count;
   end

   always_comb begin
      data_o = '0;
      if (hit_o) begin
         case (offset)
            UART_STATUS: data_o = status;
            UART_CTRL:   data_o = {30'd0, irq_en_q, tx_en_q};
            UART_BAUD:   data_o = {16'd0, div_q};
            default:     data_o = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_en_q  <= 1'b1;
         irq_en_q <= 1'b0;
         div_q    <= DEFAULT_DIV;
         ovf_q    <= 1'b0;
      end else begin
         if (wr && (offset == UART_CTRL) && sel_i[0]) begin
            tx_en_q  <= data_i[0];
            irq_en_q <= data_i[1];
         end
         if (wr && (offset == UART_BAUD)) begin
            if (sel_i[0]) div_q[7:0]  <= data_i[7:0];
            if (sel_i[1]) div_q[15:8] <= data_i[15:8];
         end
         if (wr && (offset == UART_STATUS) && sel_i[0] && data_i[3]) ovf_q <= 1'b0;
         if (push_req && fifo_full && !fifo_pop) ovf_q <= 1'b1;
      end
   end

   assign bit_end = (cnt_q == 16'd0);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      fifo_pop  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tx_en_q && !fifo_empty) begin
               fifo_pop  = 1'b1;
               shift_d   = fifo_dout;
               cnt_d     = bit_reload(div_q);
               bit_idx_d = 3'd0;
               state_d   = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) begin
               cnt_d   = bit_reload(div_q);
               state_d = ST_DATA;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               cnt_d     = bit_reload(div_q);
               shift_d   = {1'b0, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = ST_STOP;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_STOP: begin
            if (bit_end) state_d = ST_IDLE;
            else         cnt_d   = cnt_q - 16'd1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The line is registered from the current state, so it trails the FSM by one cycle.
   always_comb begin
      tx_d = 1'b1;
      case (state_q)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shift_q[0];
         default:  tx_d = 1'b1;
      endcase
      irq_d = irq_en_q && fifo_empty && (state_q == ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         irq_q     <= irq_d;
      end
   end

   assign tx_o  = tx_q;
   assign irq_o = irq_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Testbench for uart_tx_mmio: bus tasks drive the register window, a line monitor
// decodes 8N1 frames and checks them against a queue of expected bytes.
module tb_uart_tx_mmio;

   localparam logic [31:0] BASE = 32'h1FD0_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce, we;
   logic [31:0] addr, data_in;
   logic [3:0]  sel;
   logic [31:0] data_out;
   logic        hit, tx, irq;

   always #5 clk = ~clk;

   uart_tx_mmio #(
      .BASE_ADDR   (BASE),
      .FIFO_DEPTH  (8),
      .DEFAULT_DIV (16'd434)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .ce_i   (ce),
      .we_i   (we),
      .addr_i (addr),
      .sel_i  (sel),
      .data_i (data_in),
      .data_o (data_out),
      .hit_o  (hit),
      .tx_o   (tx),
      .irq_o  (irq)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] sb [$];
   int         cur_div;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Line monitor: start detected on a low sample while idle, then one sample per bit period.
   bit         mon_active = 1'b0;
   int         mon_cnt, mon_div, mon_k;
   logic [7:0] mon_byte, mon_exp;

   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         mon_active = 1'b0;
      end else if (!mon_active) begin
         if (tx === 1'b0) begin
            mon_active = 1'b1;
            mon_cnt    = 0;
            mon_div    = cur_div;
         end
      end else begin
         mon_cnt++;
         if (mon_cnt % mon_div == 0) begin
            mon_k = mon_cnt / mon_div;
            if (mon_k <= 8) begin
               mon_byte[mon_k-1] = tx;
            end else begin
               check_eq("stop_bit", {31'd0, tx}, 32'd1);
               check_eq("frame_expected", {31'd0, sb.size() != 0}, 32'd1);
               if (sb.size() != 0) begin
                  mon_exp = sb.pop_front();
                  check_eq("rx_byte", {24'd0, mon_byte}, {24'd0, mon_exp});
               end
               mon_active = 1'b0;
            end
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
      ce = 1'b1; we = 1'b1; addr = BASE + off; data_in = d; sel = s;
      @(posedge clk);
      #1;
      ce = 1'b0; we = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] off, output logic [31:0] d);
      ce = 1'b1; we = 1'b0; addr = BASE + off; sel = 4'hF;
      #1;
      d = data_out;
      ce = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [31:0] off, input logic [31:0] exp);
      logic [31:0] d;
      bus_read(off, d);
      check_eq(tag, d, exp);
   endtask

   // Write outside the window; the block must not claim it.
   task automatic write_outside(input logic [31:0] off, input logic [31:0] d);
      ce = 1'b1; we = 1'b1; addr = BASE + off; data_in = d; sel = 4'hF;
      #1;
      check_eq("out_hit", {31'd0, hit}, 32'd0);
      check_eq("out_data", data_out, 32'd0);
      @(posedge clk);
      #1;
      ce = 1'b0; we = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int i = 0;
      while (sb.size() != 0 && i < budget) begin
         @(posedge clk);
         i++;
      end
      #1;
      check_eq("drain", sb.size(), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0]  frame;
      logic [7:0]  b;
      int          lows;

      rst = 1'b0; ce = 1'b0; we = 1'b0; addr = '0; data_in = '0; sel = '0;
      cur_div = 434;
      #23;
      check_eq("rst_tx", {31'd0, tx}, 32'd1);
      check_eq("rst_irq", {31'd0, irq}, 32'd0);
      rst = 1'b1;
      wait_cycles(2);

      // 1: reset state
      read_check("status_reset", 32'h4, 32'h0000_0004);
      read_check("baud_reset", 32'hC, 32'd434);
      read_check("ctrl_reset", 32'h8, 32'h1);
      read_check("txdata_read", 32'h0, 32'h0);
      check_eq("idle_tx", {31'd0, tx}, 32'd1);
      check_eq("idle_irq", {31'd0, irq}, 32'd0);
      ce = 1'b0; addr = BASE + 32'h4; #1;
      check_eq("no_ce_hit", {31'd0, hit}, 32'd0);
      check_eq("no_ce_data", data_out, 32'd0);

      // 2: single frame, divider 4
      bus_write(32'hC, 32'd4, 4'b0011);
      read_check("baud_4", 32'hC, 32'd4);
      cur_div = 4;
      b = 8'h55;
      frame = {1'b1, b, 1'b0};
      sb.push_back(b);
      bus_write(32'h0, {24'd0, b}, 4'b0001);
      wait_cycles(1);
      check_eq("tx_pre_start", {31'd0, tx}, 32'd1);
      wait_cycles(1);
      for (int k = 0; k < 40; k++) begin
         logic [31:0] st;
         check_eq("frame55_bit", {31'd0, tx}, {31'd0, frame[k/4]});
         if (k < 39) begin
            bus_read(32'h4, st);
            check_eq("frame55_busy", {31'd0, st[0]}, 32'd1);
         end
         wait_cycles(1);
      end
      check_eq("frame55_idle", {31'd0, tx}, 32'd1);
      wait_drain(100);
      wait_cycles(4);

      // 3a: burst of 9 with divider 1; one pop coincides with the burst so all fit
      bus_write(32'hC, 32'd1, 4'b0011);
      cur_div = 1;
      for (int i = 1; i <= 9; i++) begin
         sb.push_back(8'(i));
         bus_write(32'h0, i, 4'b0001);
      end
      read_check("burst_status", 32'h4, 32'h0000_0803);
      wait_drain(300);
      wait_cycles(5);
      read_check("burst_done", 32'h4, 32'h0000_0004);

      // 3b: fill with tx disabled, push coinciding with pop, then a dropped push
      bus_write(32'h8, 32'h0, 4'b0001);
      for (int i = 0; i < 8; i++) begin
         sb.push_back(8'(8'h11 + i));
         bus_write(32'h0, 32'h11 + i, 4'b0001);
      end
      read_check("fill_status", 32'h4, 32'h0000_0802);
      bus_write(32'h8, 32'h1, 4'b0001);
      sb.push_back(8'h19);
      bus_write(32'h0, 32'h19, 4'b0001);
      read_check("full_pop_push", 32'h4, 32'h0000_0803);
      bus_write(32'h0, 32'h1A, 4'b0001);
      read_check("overflow_set", 32'h4, 32'h0000_080B);
      wait_drain(300);
      wait_cycles(5);
      read_check("ovf_sticky", 32'h4, 32'h0000_000C);
      bus_write(32'h4, 32'h8, 4'b0001);
      read_check("ovf_clear", 32'h4, 32'h0000_0004);

      // 4: interrupt, divider 2
      bus_write(32'hC, 32'd2, 4'b0011);
      cur_div = 2;
      bus_write(32'h8, 32'h3, 4'b0001);
      check_eq("irq_lag", {31'd0, irq}, 32'd0);
      wait_cycles(1);
      check_eq("irq_idle", {31'd0, irq}, 32'd1);
      sb.push_back(8'h3C);
      bus_write(32'h0, 32'h3C, 4'b0001);
      check_eq("irq_push_lag", {31'd0, irq}, 32'd1);
      for (int k = 1; k <= 21; k++) begin
         wait_cycles(1);
         check_eq("irq_frame", {31'd0, irq}, 32'd0);
      end
      wait_cycles(1);
      check_eq("irq_after_stop", {31'd0, irq}, 32'd1);
      bus_write(32'h8, 32'h1, 4'b0001);
      check_eq("irq_dis_lag", {31'd0, irq}, 32'd1);
      wait_cycles(1);
      check_eq("irq_dis", {31'd0, irq}, 32'd0);
      check_eq("sb_irq_frame", sb.size(), 32'd0);

      // 5: pause with bytes queued
      sb.push_back(8'hA1); bus_write(32'h0, 32'hA1, 4'b0001);
      sb.push_back(8'hB2); bus_write(32'h0, 32'hB2, 4'b0001);
      sb.push_back(8'hC3); bus_write(32'h0, 32'hC3, 4'b0001);
      wait_cycles(3);
      bus_write(32'h8, 32'h0, 4'b0001);
      wait_cycles(30);
      read_check("paused_status", 32'h4, 32'h0000_0200);
      check_eq("paused_sent", sb.size(), 32'd2);
      wait_cycles(20);
      read_check("paused_still", 32'h4, 32'h0000_0200);
      bus_write(32'h8, 32'h1, 4'b0001);
      wait_drain(200);
      wait_cycles(6);
      read_check("resume_done", 32'h4, 32'h0000_0004);

      // 6: asynchronous reset during data bit 3
      bus_write(32'hC, 32'd4, 4'b0011);
      cur_div = 4;
      b = 8'hA5;
      sb.push_back(b);
      bus_write(32'h0, {24'd0, b}, 4'b0001);
      wait_cycles(18);
      check_eq("bit3_before_rst", {31'd0, tx}, {31'd0, b[3]});
      #2;
      rst = 1'b0;
      #1;
      check_eq("tx_async_rst", {31'd0, tx}, 32'd1);
      check_eq("irq_async_rst", {31'd0, irq}, 32'd0);
      sb.delete();
      cur_div = 434;
      wait_cycles(2);
      rst = 1'b1;
      wait_cycles(1);
      read_check("post_rst_status", 32'h4, 32'h0000_0004);
      read_check("post_rst_baud", 32'hC, 32'd434);
      read_check("post_rst_ctrl", 32'h8, 32'h1);
      lows = 0;
      for (int k = 0; k < 40; k++) begin
         if (tx !== 1'b1) lows++;
         wait_cycles(1);
      end
      check_eq("no_residual", lows, 32'd0);

      write_outside(32'h10, 32'h0000_00FF);
      write_outside(32'h18, 32'h0000_0002);
      write_outside(32'h1C, 32'h0000_0005);
      read_check("out_status", 32'h4, 32'h0000_0004);
      read_check("out_ctrl", 32'h8, 32'h1);
      read_check("out_baud", 32'hC, 32'd434);
      lows = 0;
      for (int k = 0; k < 10; k++) begin
         if (tx !== 1'b1) lows++;
         wait_cycles(1);
      end
      check_eq("out_no_frame", lows, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the CPU data-memory port, downstream of the MEM stage.
- Consumes the same ce/we/addr/sel/data signals the datapath drives toward data RAM.
- Buffers bytes in a small FIFO and serialises them as 8N1 frames.
- Raises a level interrupt, wired to one bit of the CPU interrupt input, when the transmitter is fully drained.

Parameters:
- BASE_ADDR, 32'h1FD0_0000, base of the 16-byte register window; bits [3:0] must be zero.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, minimum 2.
- DEFAULT_DIV, 16'd434, reset value of BAUDDIV (50 MHz / 115200).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- ce_i  in  1  data-memory chip enable from the MEM stage.
- we_i  in  1  write enable.
- addr_i  in  32  byte address.
- sel_i  in  4  byte-lane select.
- data_i  in  32  write data.
- data_o  out  32  read data; combinational, valid in the same cycle as ce_i.
- hit_o  out  1  address falls in this window; used by the system bus to mux data_o against RAM.
- tx_o  out  1  serial output; idle high.
- irq_o  out  1  level interrupt.

Behaviour:
- Address decode:
  - hit_o = ce_i && addr_i[31:4] == BASE_ADDR[31:4]. Register offset = addr_i[3:2].
  - Accesses with hit_o=0 are ignored entirely.
  - data_o = 0 when hit_o=0.
- Register map:
  - 0x0 TXDATA (W): a write with sel_i[0]=1 pushes data_i[7:0] at the clock edge. Reads return 0.
  - 0x4 STATUS (R):
    - bit0 busy (serialiser not IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky)
    - bits[11:8] FIFO count
    - all other bits 0
    - Writing with data_i[3]=1 and sel_i[0]=1 clears overflow.
  - 0x8 CTRL (RW, sel_i[0]): bit0 tx_en, bit1 irq_en. Reset value 0x1.
  - 0xC BAUDDIV (RW, sel_i[1:0]): 16-bit bit period in clocks. A value of 0 is treated as 1. Reset value DEFAULT_DIV.
- Writes complete in one cycle. This block never stalls the pipeline.
- Push to a full FIFO:
  - The byte is dropped and overflow is set.
  - Exception: if a pop occurs in the same cycle, the push is accepted, count is unchanged, and overflow stays clear.
- Serialiser FSM (states IDLE, START, DATA, STOP):
  - IDLE: if tx_en && !empty, pop at the edge, load the shift register, go to START, reload the bit counter.
  - START: tx_o=0 for one bit period.
  - DATA: 8 bit periods, LSB first.
  - STOP: tx_o=1 for one bit period, then return to IDLE.
  - Back-to-back frames: IDLE lasts exactly one cycle between frames.
  - First tx_o falling edge occurs 2 cycles after the TXDATA write edge into an empty FIFO.
- Bit timing:
  - A down-counter reloads with max(BAUDDIV,1)-1 at every bit boundary.
  - A BAUDDIV write mid-bit takes effect at the next reload.
- Clearing tx_en mid-frame: the current frame completes, then no further pops occur.
- irq_o = irq_en && empty && state==IDLE. Registered, so it updates one cycle after the condition changes.
- Reset (asynchronous assert, applies mid-frame too):
  - tx_o=1, irq_o=0, state IDLE
  - FIFO emptied, overflow=0
  - CTRL=0x1, BAUDDIV=DEFAULT_DIV
- FIFO pointers are log2(FIFO_DEPTH) bits wide and wrap modulo depth. Count is a separate log2(FIFO_DEPTH)+1-bit counter.

Decomposition:
- Register offsets (`UART_TXDATA`, `UART_STATUS`, `UART_CTRL`, `UART_BAUD`), the FSM state encodings and STATUS bit indices go in the shared defines.v.
- One sub-module: uart_fifo, a synchronous FIFO parameterised by width and depth. Ports: push, pop, din, dout, full, empty, count. Push and pop in the same cycle are legal.

Test Plan:
1. Reset then read STATUS -> data_o=32'h0000_0004. Read BAUDDIV -> 434. tx_o=1, irq_o=0.
2. BAUDDIV=4, write 0x55 to TXDATA -> tx_o low 2 cycles after the write edge. Bit pattern 0,1,0,1,0,1,0,1,0,1, each held exactly 4 cycles (40-cycle frame). busy=1 throughout.
3. BAUDDIV=1, burst-write 9 bytes 0x01..0x09 on consecutive cycles while the first is still in IDLE:
   - the 9th byte is accepted only if a pop coincides, otherwise overflow=1
   - exactly the accepted bytes appear on tx_o in order
   - writing 0x8 to STATUS clears overflow
4. CTRL=0x3, push one byte with BAUDDIV=2 -> irq_o=0 during the frame. irq_o=1 one cycle after STOP ends. Clearing irq_en drops irq_o next cycle.
5. Clear tx_en mid-frame with 3 bytes queued -> the current frame finishes and count stays 2. Set tx_en -> remaining bytes transmit.
6. Assert rst low during DATA bit 3 -> tx_o=1 immediately (asynchronously). After release, STATUS=0x4 and no residual frame appears. An access at BASE_ADDR+0x10 -> hit_o=0 and no state change.
